// File: rtl/md5hf_axil_pkg.sv
// Shared definitions for the md5hf AXI4-Lite responder: response codes,
// write-channel FSM states and a small response-encoding helper.
package md5hf_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  // Map an out-of-range flag onto the AXI response code.
  function automatic logic [1:0] resp_for(input logic oor);
    logic [1:0] resp;
    if (oor) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/md5hf_axil_regbank.sv
// Storage array for the responder: byte-enabled write port, registered read
// port, whole array cleared by the asynchronous reset. A read and a write to
// the same word in one cycle returns the pre-write contents.
module md5hf_axil_regbank
  import md5hf_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 16,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                rd_en,
  input  logic                rd_zero,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem_r [WORDS];
  logic [DATA_W-1:0] rd_data_r;

  // Storage words: cleared on reset, byte lanes written where strobe is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register: captures the addressed word (or zero) on a read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data_r <= {DATA_W{1'b0}};
      end else begin
        rd_data_r <= mem_r[rd_idx];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/md5hf_axil_responder.sv
// AXI4-Lite responder exposing a small word-addressed memory. Write address
// and data are accepted independently and committed once both are present;
// reads return one cycle after the address handshake. All handshake outputs
// are registered.
module md5hf_axil_responder
  import md5hf_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int MEM_WORDS          = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam int          STRB_W     = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LIMIT = 4 * MEM_WORDS;

  // Write-side state
  wstate_e                         wstate_r, wstate_nx_s;
  logic                            aw_held_r, aw_held_nx_s;
  logic                            w_held_r, w_held_nx_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_r;
  logic [STRB_W-1:0]               w_strb_r;
  logic                            awready_r, awready_nx_s;
  logic                            wready_r, wready_nx_s;
  logic                            bvalid_r, bvalid_nx_s;
  logic [1:0]                      bresp_r, bresp_nx_s;

  // Read-side state
  logic                            arready_r, arready_nx_s;
  logic                            rvalid_r, rvalid_nx_s;
  logic [1:0]                      rresp_r, rresp_nx_s;

  // Combinational helpers
  logic                            aw_hs_s, w_hs_s, ar_hs_s;
  logic                            have_aw_s, have_w_s, commit_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr_s;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data_s;
  logic [STRB_W-1:0]               wr_strb_s;
  logic                            aw_oor_s, ar_oor_s;
  logic                            unused_s;

  assign aw_hs_s   = S_AXI_AWVALID && awready_r;
  assign w_hs_s    = S_AXI_WVALID && wready_r;
  assign ar_hs_s   = S_AXI_ARVALID && arready_r;
  assign have_aw_s = aw_held_r || aw_hs_s;
  assign have_w_s  = w_held_r || w_hs_s;
  assign wr_addr_s = aw_held_r ? aw_addr_r : S_AXI_AWADDR;
  assign wr_data_s = w_held_r ? w_data_r : S_AXI_WDATA;
  assign wr_strb_s = w_held_r ? w_strb_r : S_AXI_WSTRB;
  assign aw_oor_s  = (32'(wr_addr_s) >= ADDR_LIMIT);
  assign ar_oor_s  = (32'(S_AXI_ARADDR) >= ADDR_LIMIT);
  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Write FSM next state plus held-flag, ready, valid and response next values.
  always_comb begin
    wstate_nx_s  = wstate_r;
    aw_held_nx_s = aw_held_r;
    w_held_nx_s  = w_held_r;
    bresp_nx_s   = bresp_r;
    commit_s     = 1'b0;
    case (wstate_r)
      W_IDLE: begin
        if (have_aw_s && have_w_s) begin
          commit_s     = 1'b1;
          wstate_nx_s  = W_RESP;
          bresp_nx_s   = resp_for(aw_oor_s);
          aw_held_nx_s = 1'b0;
          w_held_nx_s  = 1'b0;
        end else begin
          aw_held_nx_s = have_aw_s;
          w_held_nx_s  = have_w_s;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_nx_s = W_IDLE;
        end else begin
          wstate_nx_s = W_RESP;
        end
      end
      default: begin
        wstate_nx_s = W_IDLE;
      end
    endcase
    bvalid_nx_s  = (wstate_nx_s == W_RESP);
    awready_nx_s = !aw_held_nx_s && !bvalid_nx_s;
    wready_nx_s  = !w_held_nx_s && !bvalid_nx_s;
  end

  // Write FSM and write-channel output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_r  <= W_IDLE;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      wstate_r  <= wstate_nx_s;
      aw_held_r <= aw_held_nx_s;
      w_held_r  <= w_held_nx_s;
      awready_r <= awready_nx_s;
      wready_r  <= wready_nx_s;
      bvalid_r  <= bvalid_nx_s;
      bresp_r   <= bresp_nx_s;
    end
  end

  // Capture address/data of a handshake that may have to wait for its partner.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_addr_r <= {C_S_AXI_ADDR_WIDTH{1'b0}};
      w_data_r  <= {C_S_AXI_DATA_WIDTH{1'b0}};
      w_strb_r  <= {STRB_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_addr_r <= S_AXI_AWADDR;
      end
      if (w_hs_s) begin
        w_data_r <= S_AXI_WDATA;
        w_strb_r <= S_AXI_WSTRB;
      end
    end
  end

  // Read channel next values: one outstanding read, ready only while idle.
  always_comb begin
    rresp_nx_s = rresp_r;
    if (ar_hs_s) begin
      rvalid_nx_s = 1'b1;
      rresp_nx_s  = resp_for(ar_oor_s);
    end else if (rvalid_r && S_AXI_RREADY) begin
      rvalid_nx_s = 1'b0;
    end else begin
      rvalid_nx_s = rvalid_r;
    end
    arready_nx_s = !rvalid_nx_s;
  end

  // Read-channel output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
    end else begin
      arready_r <= arready_nx_s;
      rvalid_r  <= rvalid_nx_s;
      rresp_r   <= rresp_nx_s;
    end
  end

  md5hf_axil_regbank #(
    .DATA_W (C_S_AXI_DATA_WIDTH),
    .WORDS  (MEM_WORDS),
    .IDX_W  (IDX_W)
  ) u_regbank (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (commit_s && !aw_oor_s),
    .wr_idx  (wr_addr_s[IDX_W+1:2]),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_en   (ar_hs_s),
    .rd_zero (ar_oor_s),
    .rd_idx  (S_AXI_ARADDR[IDX_W+1:2]),
    .rd_data (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;

endmodule

// File: doc/md5hf_axil_responder.md
MD5HF_AXIL_RESPONDER -- requirements
Module: md5hf_axil_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have parameter MEM_WORDS, default 16, number of 32-bit storage words (power of 2, 4*MEM_WORDS <= 2^C_S_AXI_ADDR_WIDTH).
REQ-004 SHALL have port ACLK, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port ARESETN, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have S_AXI_AWADDR in ADDR_WIDTH, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1: write address channel.
REQ-007 SHALL have S_AXI_WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
REQ-008 SHALL have S_AXI_BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-009 SHALL have S_AXI_ARADDR in ADDR_WIDTH, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1: read address channel.
REQ-010 SHALL have S_AXI_RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.

Function
REQ-011 SHALL act as AXI4-Lite responder, with the storage memory as target of any AXI4-Lite initiator.
REQ-012 SHALL decode word index = ADDR[log2(MEM_WORDS)+1:2]; ADDR[1:0] ignored.
REQ-013 SHALL treat address >= 4*MEM_WORDS as out-of-range: write discarded, read data 0, response SLVERR (2'b10); in-range response OKAY (2'b00).
REQ-014 SHALL accept AW and W independently in any order: AWREADY=1 while no AW held and BVALID=0; WREADY=1 while no W held and BVALID=0.
REQ-015 SHALL hold an accepted AW (or W) until its partner arrives; no second AW/W accepted meanwhile.
REQ-016 SHALL commit the write in the cycle both AW and W are available (held or same-cycle handshake), updating only bytes with WSTRB[i]=1.
REQ-017 SHALL assert BVALID the cycle after commit, keep BRESP stable, and hold BVALID until BREADY=1; held flags clear at commit.
REQ-018 SHALL implement write FSM W_IDLE -> W_RESP (on commit) -> W_IDLE (on BVALID&&BREADY).
REQ-019 SHALL set ARREADY=1 while RVALID=0; on ARVALID&&ARREADY, register RDATA/RRESP and assert RVALID next cycle (latency 1).
REQ-020 SHALL hold RVALID, RDATA, RRESP stable until RREADY=1; ARREADY returns high the cycle after RVALID&&RREADY.
REQ-021 SHALL, when read handshake and write commit hit the same word in the same cycle, return pre-write data.
REQ-022 SHALL operate read and write paths concurrently with no mutual stalling.
REQ-023 SHALL tolerate BREADY/RREADY held high permanently (back-to-back single-beat throughput of one transaction per two cycles per channel).

Reset
REQ-024 SHALL, while ARESETN=0, drive AWREADY, WREADY, BVALID, ARREADY, RVALID to 0, BRESP/RRESP/RDATA to 0, clear held flags, clear all storage words to 0, and return FSM to W_IDLE.
REQ-025 SHALL abandon any in-flight transaction on reset assertion mid-operation; no response issued afterwards.
REQ-026 SHALL raise AWREADY, WREADY, ARREADY in the first ACLK edge after ARESETN deasserts.

Structure
REQ-027 SHALL place RESP_OKAY, RESP_SLVERR, and the write-FSM state enum in shared package md5hf_axil_pkg.
REQ-028 SHALL isolate storage (byte-enabled write port, registered read port, async clear) in sub-module md5hf_axil_regbank.

Verification
REQ-029 SHALL verify: write 0x04 data 0xDEADBEEF strb 0xF, then read 0x04 -> BRESP OKAY, RDATA 0xDEADBEEF, RRESP OKAY.
REQ-030 SHALL verify: W presented 3 cycles before AW (addr 0x08, 0x12345678) -> single BVALID one cycle after AW handshake; readback 0x12345678.
REQ-031 SHALL verify: word 0x0C = 0xFFFFFFFF, write 0x00000000 strb 0x5 -> readback 0xFF00FF00.
REQ-032 SHALL verify: write/read address 0x40 -> BRESP SLVERR, RDATA 0, RRESP SLVERR; words 0x00-0x3C unchanged.
REQ-033 SHALL verify: BREADY/RREADY low for 5 cycles -> BVALID/RVALID, data, resp held stable; AWREADY, WREADY, ARREADY remain 0.
REQ-034 SHALL verify: ARESETN pulsed low while BVALID=1 -> BVALID 0 immediately, readback of written word 0x00000000.
